// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants and parser state type, used by both the RX parser
// and the transmit scheduler.
package eth_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StPayload,
        StDrain
    } rx_state_e;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    localparam int unsigned HDR_LEN     = 42;
    localparam int unsigned UDP_HDR_LEN = 8;

    localparam logic [10:0] DST_MAC_OFS   = 11'd0;
    localparam logic [10:0] ETHERTYPE_OFS = 11'd12;
    localparam logic [10:0] VER_IHL_OFS   = 11'd14;
    localparam logic [10:0] PROTO_OFS     = 11'd23;
    localparam logic [10:0] DST_IP_OFS    = 11'd30;
    localparam logic [10:0] DST_PORT_OFS  = 11'd36;
    localparam logic [10:0] UDP_LEN_OFS   = 11'd38;

endpackage

// File: rtl/udp_rx_parser.sv
// Receive-side Ethernet/IPv4/UDP header checker and payload extractor. Checks the fixed
// 42-byte header against local addresses/ports and streams the UDP payload to the sinks.
module udp_rx_parser
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC   = 48'h0012_3456_7890,
    parameter logic [31:0] LOCAL_IP    = 32'hC0A8_0004,
    parameter logic [15:0] VIDEO_PORT  = 16'h0400,
    parameter logic [15:0] AUDIO_PORT  = 16'h0401,
    parameter int unsigned MAX_PAYLOAD = 1024
) (
    input  logic        clk_50mhz_i,
    input  logic        eth_rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_sof_i,
    input  logic        rx_eof_i,
    output logic [7:0]  pl_data_o,
    output logic        pl_valid_o,
    output logic        pl_last_o,
    output logic        pl_abort_o,
    output logic        audio_video_o,
    output logic [10:0] pl_len_o,
    output logic        frame_ok_o,
    output logic        frame_drop_o,
    output logic [15:0] drop_cnt_o
);

    localparam logic [10:0] HDR_LAST = 11'(HDR_LEN - 1);

    rx_state_e   state_q;
    logic [10:0] cnt_q;
    logic [7:0]  port_hi_q;
    logic [15:0] udp_len_q;
    logic        abort_pend_q;
    logic [7:0]  pl_data_q;
    logic        pl_valid_q, pl_last_q, pl_abort_q, audio_video_q, frame_ok_q, frame_drop_q;
    logic [10:0] pl_len_q;
    logic [15:0] drop_cnt_q;

    logic [10:0] hdr_idx;
    logic [1:0]  ip_ofs;
    logic [7:0]  mac_byte, ip_byte;
    logic [15:0] port_w, pl_len_w;
    logic        hdr_bad, len_bad, hdr_step;

    // A byte carrying rx_sof is always header byte 0, whatever state we were in.
    always_comb begin
        hdr_idx  = rx_sof_i ? DST_MAC_OFS : cnt_q;
        hdr_step = rx_sof_i || (state_q == StHeader);
        ip_ofs   = hdr_idx[1:0] - DST_IP_OFS[1:0];
        mac_byte = 8'(LOCAL_MAC >> (6'd40 - {hdr_idx[2:0], 3'b000}));
        ip_byte  = 8'(LOCAL_IP >> (5'd24 - {ip_ofs, 3'b000}));
        port_w   = {port_hi_q, rx_data_i};
        hdr_bad  = 1'b0;
        if (hdr_idx < DST_MAC_OFS + 11'd6) begin
            hdr_bad = rx_data_i != mac_byte;
        end else if (hdr_idx == ETHERTYPE_OFS) begin
            hdr_bad = rx_data_i != ETHERTYPE_IPV4[15:8];
        end else if (hdr_idx == ETHERTYPE_OFS + 11'd1) begin
            hdr_bad = rx_data_i != ETHERTYPE_IPV4[7:0];
        end else if (hdr_idx == VER_IHL_OFS) begin
            hdr_bad = rx_data_i != IPV4_VER_IHL;
        end else if (hdr_idx == PROTO_OFS) begin
            hdr_bad = rx_data_i != IP_PROTO_UDP;
        end else if (hdr_idx >= DST_IP_OFS && hdr_idx < DST_IP_OFS + 11'd4) begin
            hdr_bad = rx_data_i != ip_byte;
        end else if (hdr_idx == DST_PORT_OFS) begin
            hdr_bad = rx_data_i != VIDEO_PORT[15:8] && rx_data_i != AUDIO_PORT[15:8];
        end else if (hdr_idx == DST_PORT_OFS + 11'd1) begin
            hdr_bad = port_w != VIDEO_PORT && port_w != AUDIO_PORT;
        end
        pl_len_w = udp_len_q - 16'(UDP_HDR_LEN);
        len_bad  = udp_len_q < 16'(UDP_HDR_LEN) || pl_len_w > 16'(MAX_PAYLOAD);
    end

    always_ff @(posedge clk_50mhz_i or posedge eth_rst_i) begin
        if (eth_rst_i) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            port_hi_q     <= '0;
            udp_len_q     <= '0;
            abort_pend_q  <= 1'b0;
            pl_data_q     <= '0;
            pl_valid_q    <= 1'b0;
            pl_last_q     <= 1'b0;
            pl_abort_q    <= 1'b0;
            audio_video_q <= 1'b0;
            pl_len_q      <= '0;
            frame_ok_q    <= 1'b0;
            frame_drop_q  <= 1'b0;
        end else begin
            pl_valid_q   <= 1'b0;
            pl_last_q    <= 1'b0;
            frame_ok_q   <= 1'b0;
            abort_pend_q <= 1'b0;
            // A payload cut short by rx_eof is reported one cycle after its last byte.
            pl_abort_q   <= abort_pend_q;
            frame_drop_q <= abort_pend_q;
            if (rx_valid_i) begin
                if (rx_sof_i && state_q == StPayload) begin
                    pl_abort_q   <= 1'b1;
                    frame_drop_q <= 1'b1;
                end else if (rx_sof_i && state_q == StHeader) begin
                    frame_drop_q <= 1'b1;
                end
                if (hdr_step) begin
                    cnt_q <= hdr_idx + 11'd1;
                    if (hdr_idx == DST_PORT_OFS) port_hi_q <= rx_data_i;
                    if (hdr_idx == DST_PORT_OFS + 11'd1 && !hdr_bad) begin
                        audio_video_q <= (port_w == AUDIO_PORT);
                    end
                    if (hdr_idx == UDP_LEN_OFS) udp_len_q[15:8] <= rx_data_i;
                    if (hdr_idx == UDP_LEN_OFS + 11'd1) udp_len_q[7:0] <= rx_data_i;
                    if (hdr_bad) begin
                        frame_drop_q <= 1'b1;
                        state_q      <= rx_eof_i ? StIdle : StDrain;
                    end else if (hdr_idx == HDR_LAST) begin
                        if (len_bad) begin
                            frame_drop_q <= 1'b1;
                            state_q      <= rx_eof_i ? StIdle : StDrain;
                        end else if (pl_len_w == 16'd0) begin
                            frame_ok_q <= 1'b1;
                            state_q    <= rx_eof_i ? StIdle : StDrain;
                        end else if (rx_eof_i) begin
                            frame_drop_q <= 1'b1;
                            state_q      <= StIdle;
                        end else begin
                            pl_len_q <= pl_len_w[10:0];
                            cnt_q    <= '0;
                            state_q  <= StPayload;
                        end
                    end else if (rx_eof_i) begin
                        frame_drop_q <= 1'b1;
                        state_q      <= StIdle;
                    end else begin
                        state_q <= StHeader;
                    end
                end else if (state_q == StPayload) begin
                    pl_data_q  <= rx_data_i;
                    pl_valid_q <= 1'b1;
                    cnt_q      <= cnt_q + 11'd1;
                    if (cnt_q == pl_len_q - 11'd1) begin
                        pl_last_q  <= 1'b1;
                        frame_ok_q <= 1'b1;
                        state_q    <= rx_eof_i ? StIdle : StDrain;
                    end else if (rx_eof_i) begin
                        abort_pend_q <= 1'b1;
                        state_q      <= StIdle;
                    end
                end else if (state_q == StDrain && rx_eof_i) begin
                    state_q <= StIdle;
                end
            end
        end
    end

    always_ff @(posedge clk_50mhz_i or posedge eth_rst_i) begin
        if (eth_rst_i) begin
            drop_cnt_q <= '0;
        end else if (frame_drop_q && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign pl_data_o     = pl_data_q;
    assign pl_valid_o    = pl_valid_q;
    assign pl_last_o     = pl_last_q;
    assign pl_abort_o    = pl_abort_q;
    assign audio_video_o = audio_video_q;
    assign pl_len_o      = pl_len_q;
    assign frame_ok_o    = frame_ok_q;
    assign frame_drop_o  = frame_drop_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Self-checking bench for udp_rx_parser: directed frames plus randomized frames checked
// against a frame-level reference model.
module tb_udp_rx_parser;

    localparam logic [47:0] MAC = 48'h0012_3456_7890;
    localparam logic [31:0] IP  = 32'hC0A8_0004;
    localparam logic [15:0] VP  = 16'h0400;
    localparam logic [15:0] AP  = 16'h0401;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0;
    logic [7:0]  pl_data;
    logic        pl_valid, pl_last, pl_abort, audio_video, frame_ok, frame_drop;
    logic [10:0] pl_len;
    logic [15:0] drop_cnt;

    int n_chk = 0, n_fail = 0;
    int ok_tot = 0, drop_tot = 0, abort_tot = 0, last_tot = 0;
    int exp_ok = 0, exp_drop = 0, exp_abort = 0, exp_last = 0, exp_dcnt = 0;
    logic [7:0] q[$];
    logic [7:0] qb[$];

    udp_rx_parser dut (
        .clk_50mhz_i   (clk),
        .eth_rst_i     (rst),
        .rx_data_i     (rx_data),
        .rx_valid_i    (rx_valid),
        .rx_sof_i      (rx_sof),
        .rx_eof_i      (rx_eof),
        .pl_data_o     (pl_data),
        .pl_valid_o    (pl_valid),
        .pl_last_o     (pl_last),
        .pl_abort_o    (pl_abort),
        .audio_video_o (audio_video),
        .pl_len_o      (pl_len),
        .frame_ok_o    (frame_ok),
        .frame_drop_o  (frame_drop),
        .drop_cnt_o    (drop_cnt)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (frame_ok)   ok_tot    <= ok_tot + 1;
        if (frame_drop) drop_tot  <= drop_tot + 1;
        if (pl_abort)   abort_tot <= abort_tot + 1;
        if (pl_last)    last_tot  <= last_tot + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pl_data"}, pl_data, 0);
        check({tag, "_pl_valid"}, pl_valid, 0);
        check({tag, "_pl_last"}, pl_last, 0);
        check({tag, "_pl_abort"}, pl_abort, 0);
        check({tag, "_audio_video"}, audio_video, 0);
        check({tag, "_pl_len"}, pl_len, 0);
        check({tag, "_frame_ok"}, frame_ok, 0);
        check({tag, "_frame_drop"}, frame_drop, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    task automatic build(input logic [47:0] mac, input logic [15:0] et, input logic [7:0] vihl,
                         input logic [7:0] proto, input logic [31:0] ip, input logic [15:0] port,
                         input logic [15:0] ulen, input int npay, input int npad,
                         output logic [7:0] f[$]);
        f.delete();
        for (int i = 0; i < 42 + npay + npad; i++) f.push_back(8'($urandom));
        for (int i = 0; i < 6; i++) f[i] = mac[8*(5-i) +: 8];
        f[12] = et[15:8];
        f[13] = et[7:0];
        f[14] = vihl;
        f[23] = proto;
        for (int i = 0; i < 4; i++) f[30+i] = ip[8*(3-i) +: 8];
        f[36] = port[15:8];
        f[37] = port[7:0];
        f[38] = ulen[15:8];
        f[39] = ulen[7:0];
    endtask

    task automatic good(input logic [15:0] port, input int len, input int npad,
                        output logic [7:0] f[$]);
        build(MAC, 16'h0800, 8'h45, 8'h11, IP, port, 16'(len + 8), len, npad, f);
    endtask

    // Frame-level outcome: what a correct parser must do with the whole byte list.
    task automatic model(input logic [7:0] f[$], output int fwd, output bit ok, output bit drop,
                         output bit abort, output bit av, output int len);
        int n;
        logic [15:0] port, ulen;
        bit hdr_ok;
        n = f.size();
        fwd = 0; ok = 0; drop = 0; abort = 0; av = 0; len = 0;
        if (n < 42) begin
            drop = 1;
            return;
        end
        port = {f[36], f[37]};
        ulen = {f[38], f[39]};
        hdr_ok = ({f[0], f[1], f[2], f[3], f[4], f[5]} == MAC) && ({f[12], f[13]} == 16'h0800)
                 && (f[14] == 8'h45) && (f[23] == 8'h11)
                 && ({f[30], f[31], f[32], f[33]} == IP) && (port == VP || port == AP);
        if (!hdr_ok || ulen < 16'd8 || int'(ulen) - 8 > 1024) begin
            drop = 1;
            return;
        end
        len = int'(ulen) - 8;
        av  = (port == AP);
        if (len == 0) begin
            ok = 1;
        end else if (n - 42 >= len) begin
            fwd = len;
            ok  = 1;
        end else begin
            fwd   = n - 42;
            drop  = 1;
            abort = (fwd > 0);
        end
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit eof_last, input int gap_pct,
                              input int idle_after, input int flag_at, input bit flag_abort);
        int fwd, len, last_idx, gaps;
        bit ok, drop, abort, av, exp_v;
        model(f, fwd, ok, drop, abort, av, len);
        last_idx = (ok && len > 0) ? 42 + len - 1 : -1;
        for (int i = 0; i < f.size(); i++) begin
            gaps = ($urandom_range(0, 99) < gap_pct) ? $urandom_range(1, 3) : 0;
            for (int g = 0; g < gaps; g++) begin
                rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
                @(posedge clk); #1;
                check("gap_pl_valid", pl_valid, 0);
            end
            rx_valid = 1'b1;
            rx_data  = f[i];
            rx_sof   = (i == 0);
            rx_eof   = eof_last && (i == f.size() - 1);
            @(posedge clk); #1;
            exp_v = (i >= 42) && (i < 42 + fwd);
            check("pl_valid", pl_valid, exp_v);
            if (exp_v) begin
                check("pl_data", pl_data, f[i]);
                check("audio_video", audio_video, av);
                check("pl_len", pl_len, len);
            end
            if (i == last_idx) begin
                check("pl_last", pl_last, 1);
                check("frame_ok_with_last", frame_ok, 1);
            end
            if (i == flag_at) begin
                check("flag_frame_drop", frame_drop, 1);
                check("flag_pl_abort", pl_abort, flag_abort);
            end
        end
        rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
        exp_ok    += ok;
        exp_drop  += drop;
        exp_abort += abort;
        exp_last  += (last_idx >= 0);
        if (drop && exp_dcnt < 65535) exp_dcnt++;
        for (int k = 0; k < idle_after; k++) begin
            @(posedge clk); #1;
            check("idle_pl_valid", pl_valid, 0);
            if (k == 0) check("pl_abort_timing", pl_abort, abort);
        end
        if (idle_after > 0) begin
            check("frame_ok_total", ok_tot, exp_ok);
            check("frame_drop_total", drop_tot, exp_drop);
            check("pl_abort_total", abort_tot, exp_abort);
            check("pl_last_total", last_tot, exp_last);
            check("drop_cnt", drop_cnt, exp_dcnt);
        end
    endtask

    initial begin
        int err, len, npay, npad, keep;
        logic [47:0] mac;
        logic [15:0] et, port, ulen;
        logic [7:0]  vihl, proto;
        logic [31:0] ip;

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        good(VP, 4, 18, q);
        q[42] = 8'hA1; q[43] = 8'hB2; q[44] = 8'hC3; q[45] = 8'hD4;
        send_frame(q, 1, 0, 3, -1, 0);
        check("video_drop_cnt", drop_cnt, 0);

        good(VP, 4, 18, q);
        q[5] = 8'h91;
        send_frame(q, 1, 0, 3, 5, 0);
        check("mac_drop_cnt", drop_cnt, 1);
        good(AP, 8, 10, q);
        send_frame(q, 1, 30, 3, -1, 0);

        build(MAC, 16'h0800, 8'h45, 8'h11, IP, VP, 16'h0409, 20, 0, q);
        send_frame(q, 1, 0, 3, 41, 0);
        build(MAC, 16'h0800, 8'h45, 8'h11, IP, VP, 16'h0008, 0, 18, q);
        send_frame(q, 1, 0, 3, -1, 0);

        build(MAC, 16'h0800, 8'h45, 8'h11, IP, VP, 16'h0010, 3, 0, q);
        send_frame(q, 1, 0, 3, -1, 0);

        good(VP, 20, 0, q);
        while (q.size() > 47) void'(q.pop_back());
        send_frame(q, 0, 0, 0, -1, 0);
        good(AP, 6, 10, qb);
        send_frame(qb, 1, 0, 3, 0, 1);

        good(AP, 1024, 0, q);
        send_frame(q, 1, 0, 3, -1, 0);
        check("audio_last_av", audio_video, 1);

        good(VP, 10, 0, q);
        for (int i = 0; i < 10; i++) begin
            rx_valid = 1'b1; rx_data = q[i]; rx_sof = (i == 0); rx_eof = 1'b0;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0; rx_sof = 1'b0;
        #3 rst = 1'b1;
        #1 check_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_dcnt = 0;
        good(VP, 5, 5, q);
        send_frame(q, 1, 0, 3, -1, 0);

        for (int fr = 0; fr < 40; fr++) begin
            err = $urandom_range(0, 12);
            len = $urandom_range(0, 48);
            mac = MAC; et = 16'h0800; vihl = 8'h45; proto = 8'h11; ip = IP;
            port = $urandom_range(0, 1) ? AP : VP;
            ulen = 16'(len + 8);
            npay = len;
            npad = $urandom_range(0, 20);
            case (err)
                1: mac = mac ^ (48'h1 << (8 * $urandom_range(0, 5)));
                2: et = et ^ 16'h0100;
                3: vihl = 8'h46;
                4: proto = 8'h06;
                5: ip = ip ^ 32'h0001_0000;
                6: port = 16'h0402;
                7: ulen = 16'($urandom_range(0, 7));
                8: begin ulen = 16'(1033 + $urandom_range(0, 100)); npay = 10; end
                10: if (len > 1) begin npay = $urandom_range(1, len - 1); npad = 0; end
                default: ;
            endcase
            build(mac, et, vihl, proto, ip, port, ulen, npay, npad, q);
            if (err == 9) begin
                keep = $urandom_range(1, 41);
                while (q.size() > keep) void'(q.pop_back());
            end
            send_frame(q, 1, 20, 3, -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
